// File: rtl/ddr_stub_responder.sv
// ddr_stub_responder: block-RAM stand-in for the DDR2 controller client port.
// Ports: Address/Read/WriteAF/AFfull, WriteData/WriteWB/WBfull, ReadData/ReadRB/RBempty/RBfull.

module ddr_stub_fifo #(
  parameter  int W  = 8,
  parameter  int D  = 4,
  localparam int PW = $clog2(D),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // a pop on a full FIFO frees the slot a same-edge push uses
  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wp_q <= wp_q + PW'(1);
      if (pop_ok)  rp_q <= rp_q + PW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(D));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign cnt_o   = cnt_q;

endmodule

module ddr_stub_responder #(
  parameter int AF_DEPTH = 16,
  parameter int WB_DEPTH = 32,
  parameter int RB_DEPTH = 32,
  parameter int MEM_AW   = 10,
  parameter int READ_LAT = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [27:0]  Address,
  input  logic         Read,
  input  logic         WriteAF,
  output logic         AFfull,
  input  logic [127:0] WriteData,
  input  logic         WriteWB,
  output logic         WBfull,
  output logic [127:0] ReadData,
  input  logic         ReadRB,
  output logic         RBempty,
  output logic         RBfull
);

  localparam int LW  = MEM_AW - 1;
  localparam int AFC = $clog2(AF_DEPTH) + 1;
  localparam int WBC = $clog2(WB_DEPTH) + 1;
  localparam int RBC = $clog2(RB_DEPTH) + 1;
  localparam int RBU = RBC + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_WR1, S_RD0, S_RD1
  } state_t;

  state_t         state_q;
  logic [LW-1:0]  line_q;
  logic [RBC-1:0] infl_q, infl_d;

  logic [LW:0]    af_head;
  logic           af_empty, af_pop;
  logic [AFC-1:0] unused_af_cnt;
  logic           unused_addr;
  logic [127:0]   wb_head;
  logic [WBC-1:0] wb_cnt;
  logic           unused_wb_empty;
  logic [127:0]   rb_head;
  logic [RBC-1:0] rb_cnt;
  logic           rb_empty, rb_full, rb_push;

  logic           head_rd, wr_take, rd_take, rd_room;
  logic           wr_en, rd_en, beat;
  logic [RBU-1:0] rb_use;
  logic [MEM_AW-1:0] arr_idx;

  logic [127:0]        arr_q [2**MEM_AW];
  logic [READ_LAT-1:0] pipe_v_q;
  logic [127:0]        pipe_d_q [READ_LAT];

  assign unused_addr = ^Address[27:LW];

  ddr_stub_fifo #(.W(MEM_AW), .D(AF_DEPTH)) u_af (
    .clk_i(CLK), .rst_i(Reset),
    .push_i(WriteAF), .din_i({Read, Address[LW-1:0]}),
    .pop_i(af_pop), .dout_o(af_head),
    .full_o(AFfull), .empty_o(af_empty), .cnt_o(unused_af_cnt)
  );

  ddr_stub_fifo #(.W(128), .D(WB_DEPTH)) u_wb (
    .clk_i(CLK), .rst_i(Reset),
    .push_i(WriteWB), .din_i(WriteData),
    .pop_i(wr_en), .dout_o(wb_head),
    .full_o(WBfull), .empty_o(unused_wb_empty), .cnt_o(wb_cnt)
  );

  ddr_stub_fifo #(.W(128), .D(RB_DEPTH)) u_rb (
    .clk_i(CLK), .rst_i(Reset),
    .push_i(rb_push), .din_i(pipe_d_q[READ_LAT-1]),
    .pop_i(ReadRB), .dout_o(rb_head),
    .full_o(rb_full), .empty_o(rb_empty), .cnt_o(rb_cnt)
  );

  // a read is only started if both beats are guaranteed an RB slot
  assign rb_use  = RBU'(rb_cnt) + RBU'(infl_q) + RBU'(2);
  assign rd_room = (rb_use <= RBU'(RB_DEPTH));

  assign head_rd = af_head[LW];
  assign wr_take = (state_q == S_IDLE) && !af_empty && !head_rd
                && (wb_cnt >= WBC'(2));
  assign rd_take = (state_q == S_IDLE) && !af_empty && head_rd
                && rd_room;
  assign af_pop  = wr_take || rd_take;

  assign wr_en   = !Reset && ((state_q == S_WR0) || (state_q == S_WR1));
  assign rd_en   = !Reset && ((state_q == S_RD0) || (state_q == S_RD1));
  assign beat    = (state_q == S_WR1) || (state_q == S_RD1);
  assign arr_idx = {line_q, beat};
  assign rb_push = pipe_v_q[READ_LAT-1];

  // in-flight words are reserved when the read command is accepted
  assign infl_d = infl_q + (rd_take ? RBC'(2) : '0) - RBC'(rb_push);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      infl_q  <= '0;
    end else begin
      infl_q <= infl_d;
      unique case (state_q)
        S_IDLE: begin
          if (wr_take) begin
            state_q <= S_WR0;
            line_q  <= af_head[LW-1:0];
          end else if (rd_take) begin
            state_q <= S_RD0;
            line_q  <= af_head[LW-1:0];
          end
        end
        S_WR0:   state_q <= S_WR1;
        S_WR1:   state_q <= S_IDLE;
        S_RD0:   state_q <= S_RD1;
        S_RD1:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) arr_q[arr_idx] <= wb_head;
    if (rd_en) pipe_d_q[0] <= arr_q[arr_idx];
    for (int k = 1; k < READ_LAT; k++) begin
      pipe_d_q[k] <= pipe_d_q[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) pipe_v_q <= '0;
    else       pipe_v_q <= (pipe_v_q << 1) | READ_LAT'(rd_en);
  end

  assign ReadData = rb_empty ? '0 : rb_head;
  assign RBempty  = rb_empty;
  assign RBfull   = rb_full;

endmodule
